// File: rtl/swipt_frame_rx.sv
// rtl/swipt_frame_rx.sv - SWIPT downlink frame receiver
// Samples a 36-bit MSB-first frame at mid-bit and validates preamble, pairs, parity and trailer.
module swipt_frame_rx #(
  parameter int BIT_PERIOD = 200000,
  parameter int CNT_W      = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable_i,
  input  logic        rx_in_i,
  output logic        busy_o,
  output logic        frame_valid_o,
  output logic        frame_err_o,
  output logic [3:0]  err_flags_o,
  output logic [1:0]  mode_o,
  output logic [1:0]  type_o,
  output logic [15:0] data_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_CHECK} state_t;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_PERIOD - 1);

  state_t            state_q, state_d;
  logic              rx_m_q, rx_s_q, rx_p_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        bitcnt_q, bitcnt_d;
  logic [34:0]       sh_q, sh_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic [3:0]        flags_q, flags_d;
  logic [1:0]        mode_q, mode_d, type_q, type_d;
  logic [15:0]       data_q, data_d;
  logic [35:0]       frame_w;
  logic [3:0]        chk_w;

  // Bits 35..1 are held in sh_q; the full frame exists only as bit 0 arrives.
  assign frame_w = {sh_q, rx_s_q};

  always_comb begin
    chk_w[0] = frame_w[35:30] != 6'b101010;
    chk_w[1] = (frame_w[29] == frame_w[28]) | (frame_w[27] == frame_w[26]) |
               (frame_w[25] == frame_w[24]) | (frame_w[23] == frame_w[22]);
    chk_w[2] = (frame_w[4] != ^frame_w[21:6]) | (frame_w[5] == frame_w[4]);
    chk_w[3] = frame_w[3:0] != 4'b0101;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    flags_d  = flags_q;
    mode_d   = mode_q;
    type_d   = type_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (rx_s_q && !rx_p_q) begin
          cnt_d    = HALF_LOAD;
          bitcnt_d = 6'd35;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            sh_d     = {sh_q[33:0], 1'b1};
            cnt_d    = FULL_LOAD;
            bitcnt_d = 6'd34;
            state_d  = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          sh_d = {sh_q[33:0], rx_s_q};
          if (bitcnt_q == 6'd0) begin
            // Results register here so the strobe and decoded fields share the CHECK cycle.
            state_d = S_CHECK;
            valid_d = ~|chk_w;
            err_d   = |chk_w;
            flags_d = chk_w;
            if (~|chk_w) begin
              mode_d = {frame_w[28], frame_w[26]};
              type_d = {frame_w[24], frame_w[22]};
              data_d = frame_w[21:6];
            end
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
            cnt_d    = FULL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_m_q   <= 1'b0;
      rx_s_q   <= 1'b0;
      rx_p_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sh_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      flags_q  <= '0;
      mode_q   <= '0;
      type_q   <= '0;
      data_q   <= '0;
    end else begin
      rx_m_q <= rx_in_i;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
      if (!enable_i) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        bitcnt_q <= bitcnt_d;
        sh_q     <= sh_d;
        valid_q  <= valid_d;
        err_q    <= err_d;
        flags_q  <= flags_d;
        mode_q   <= mode_d;
        type_q   <= type_d;
        data_q   <= data_d;
      end
    end
  end

  assign busy_o        = (state_q == S_START) || (state_q == S_DATA);
  assign frame_valid_o = valid_q;
  assign frame_err_o   = err_q;
  assign err_flags_o   = flags_q;
  assign mode_o        = mode_q;
  assign type_o        = type_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_swipt_frame_rx.sv
// tb/tb_swipt_frame_rx.sv - directed self-checking bench for swipt_frame_rx
module tb_swipt_frame_rx;
  localparam int BP = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable = 1'b1;
  logic        rx_in = 1'b0;
  logic        busy, frame_valid, frame_err;
  logic [3:0]  err_flags;
  logic [1:0]  mode, ftype;
  logic [15:0] data;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_valid_cyc = 0;
  int t_rise = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [35:0] f;

  swipt_frame_rx #(.BIT_PERIOD(BP), .CNT_W(20)) dut (
    .clk(clk), .nrst(nrst), .enable_i(enable), .rx_in_i(rx_in),
    .busy_o(busy), .frame_valid_o(frame_valid), .frame_err_o(frame_err),
    .err_flags_o(err_flags), .mode_o(mode), .type_o(ftype), .data_o(data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [1:0] m, input logic [1:0] t, input logic [15:0] d);
    return {6'b101010, ~m[1], m[1], ~m[0], m[0], ~t[1], t[1], ~t[0], t[0], d, ~^d, ^d, 4'b0101};
  endfunction

  // Drives the frame MSB first; abort_bit >= 0 drops enable for one cycle mid-bit and ends the frame.
  task automatic send(input logic [35:0] fr, input int abort_bit);
    @(posedge clk); #1;
    t_rise = cyc;
    for (int i = 35; i >= 0; i--) begin
      rx_in = fr[i];
      if (i == abort_bit) begin
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        rx_in = 1'b0;
        return;
      end
      repeat (BP) @(posedge clk);
      #1;
    end
    rx_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(4);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_valid", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_flags", 32'(err_flags), 32'h0);
    chk("reset_mode", 32'(mode), 32'h0);
    chk("reset_type", 32'(ftype), 32'h0);
    chk("reset_data", 32'(data), 32'h0);
    nrst = 1'b1;
    idle(4);

    send(mk(2'b10, 2'b01, 16'hA5C3), -1);
    idle(2);
    chk("v1_count", 32'(n_valid), 32'd1);
    chk("v1_errcount", 32'(n_err), 32'd0);
    chk("v1_latency", 32'(last_valid_cyc - t_rise), 32'd287);
    chk("v1_mode", 32'(mode), 32'h2);
    chk("v1_type", 32'(ftype), 32'h1);
    chk("v1_data", 32'(data), 32'hA5C3);
    chk("v1_flags", 32'(err_flags), 32'h0);
    chk("v1_busy", 32'(busy), 32'h0);
    idle(BP);

    f = mk(2'b10, 2'b01, 16'hA5C3);
    f[4] = ~f[4];
    send(f, -1);
    idle(2);
    chk("par_errcount", 32'(n_err), 32'd1);
    chk("par_validcount", 32'(n_valid), 32'd1);
    chk("par_flags", 32'(err_flags), 32'h4);
    chk("par_data", 32'(data), 32'hA5C3);
    chk("par_mode", 32'(mode), 32'h2);
    idle(BP);

    f = mk(2'b10, 2'b01, 16'hA5C3);
    f[29] = 1'b1;
    f[28] = 1'b1;
    f[3:0] = 4'b0111;
    send(f, -1);
    idle(2);
    chk("pt_errcount", 32'(n_err), 32'd2);
    chk("pt_flags", 32'(err_flags), 32'hA);
    chk("pt_data", 32'(data), 32'hA5C3);
    idle(BP);

    @(posedge clk); #1;
    rx_in = 1'b1;
    idle(2);
    rx_in = 1'b0;
    idle(1);
    chk("fs_busy_high", 32'(busy), 32'h1);
    idle(12);
    chk("fs_busy_low", 32'(busy), 32'h0);
    chk("fs_no_valid", 32'(n_valid), 32'd1);
    chk("fs_no_err", 32'(n_err), 32'd2);
    send(mk(2'b01, 2'b10, 16'h5A5A), -1);
    idle(2);
    chk("fs_next_count", 32'(n_valid), 32'd2);
    chk("fs_next_mode", 32'(mode), 32'h1);
    chk("fs_next_type", 32'(ftype), 32'h2);
    chk("fs_next_data", 32'(data), 32'h5A5A);
    idle(BP);

    send(mk(2'b11, 2'b00, 16'h0001), 20);
    chk("ab_busy", 32'(busy), 32'h0);
    idle(3 * BP);
    chk("ab_no_valid", 32'(n_valid), 32'd2);
    chk("ab_no_err", 32'(n_err), 32'd2);
    send(mk(2'b11, 2'b00, 16'h0001), -1);
    idle(2);
    chk("ab_count", 32'(n_valid), 32'd3);
    chk("ab_data", 32'(data), 32'h0001);
    chk("ab_mode", 32'(mode), 32'h3);
    chk("ab_errcount", 32'(n_err), 32'd2);
    idle(BP);

    send(mk(2'b00, 2'b11, 16'h1234), -1);
    chk("bb1_data", 32'(data), 32'h1234);
    chk("bb1_count", 32'(n_valid), 32'd4);
    idle(BP - 1);
    send(mk(2'b01, 2'b01, 16'hFFFF), -1);
    idle(2);
    chk("bb2_count", 32'(n_valid), 32'd5);
    chk("bb2_data", 32'(data), 32'hFFFF);
    chk("bb2_latency", 32'(last_valid_cyc - t_rise), 32'd287);
    chk("bb2_errcount", 32'(n_err), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
